// File: rtl/fetch_decode_queue.sv
// Decoupling instruction queue between Fetch and Decode: DEPTH-entry in-order
// FIFO with Decode ready/valid handshake, Fetch backpressure and one-cycle flush.
package fetch_decode_queue_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        prd_taken;
    logic        valid;
  } fetch_t;
endpackage

module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  fetch_t        i_fetch_pkg,
  input  logic          i_flush,
  output logic          o_fetch_buff_en,
  output fetch_t        o_dec_pkg,
  output logic          o_dec_valid,
  input  logic          i_dec_ready,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign full            = (count == CW'(DEPTH));
  // Flush must force the enable so a full queue never swallows the PC redirect.
  assign o_fetch_buff_en = !full || i_flush;
  assign o_dec_valid     = (count != '0);
  assign push            = o_fetch_buff_en && i_fetch_pkg.valid && !i_flush;
  assign pop             = o_dec_valid && i_dec_ready && !i_flush;
  assign o_count         = count;

  always_comb begin
    o_dec_pkg = '0;
    if (o_dec_valid) begin
      o_dec_pkg       = mem[rd_ptr];
      o_dec_pkg.valid = 1'b1;
    end
  end

  // Storage is left unreset; only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_fetch_pkg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          i_clk;
  logic          i_rstn;
  fetch_t        i_fetch_pkg;
  logic          i_flush;
  logic          o_fetch_buff_en;
  fetch_t        o_dec_pkg;
  logic          o_dec_valid;
  logic          i_dec_ready;
  logic [CW-1:0] o_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_fetch_pkg     (i_fetch_pkg),
    .i_flush         (i_flush),
    .o_fetch_buff_en (o_fetch_buff_en),
    .o_dec_pkg       (o_dec_pkg),
    .o_dec_valid     (o_dec_valid),
    .i_dec_ready     (i_dec_ready),
    .o_count         (o_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic fetch_t mk(input logic [31:0] pc, input logic v);
    fetch_t p;
    p.instr     = {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
    p.pc        = pc;
    p.prd_taken = pc[2];
    p.valid     = v;
    return p;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_flush = 1'b0; i_dec_ready = 1'b0; i_fetch_pkg = mk(32'h0, 1'b1);
    #3;
    n_checks++; if (o_count !== 0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_checks++; if (o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_dec_valid); end
    n_checks++; if (o_dec_pkg !== fetch_t'('0)) begin n_fail++; $display("FAIL reset_pkg got %h exp 0", o_dec_pkg); end
    n_checks++; if (o_fetch_buff_en !== 1'b1) begin n_fail++; $display("FAIL reset_en got %b exp 1", o_fetch_buff_en); end
    step();
    step();
    i_rstn = 1'b1;
  endtask

  task automatic test_fill();
    i_dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_fetch_pkg = mk(32'(4 * i), 1'b1);
      step();
      n_checks++; if (o_count !== i + 1) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, o_count, i + 1); end
    end
    n_checks++; if (o_fetch_buff_en !== 1'b0) begin n_fail++; $display("FAIL fill_en got %b exp 0", o_fetch_buff_en); end
    n_checks++; if (o_dec_pkg !== mk(32'h0, 1'b1)) begin n_fail++; $display("FAIL fill_head got %h exp %h", o_dec_pkg, mk(32'h0, 1'b1)); end
    i_fetch_pkg = mk(32'h10, 1'b1);
    step();
    n_checks++; if (o_count !== 4) begin n_fail++; $display("FAIL held_count got %0d exp 4", o_count); end
    n_checks++; if (o_dec_pkg.pc !== 32'h0) begin n_fail++; $display("FAIL held_head_pc got %h exp 0", o_dec_pkg.pc); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_pc;
    i_fetch_pkg = mk(32'h10, 1'b1);
    i_dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_pc = (i < 4) ? 32'(4 * i) : 32'h10;
      n_checks++; if (o_dec_pkg !== mk(exp_pc, 1'b1)) begin n_fail++; $display("FAIL drain_pkg[%0d] got %h exp %h", i, o_dec_pkg, mk(exp_pc, 1'b1)); end
      step();
      if (i == 0) begin
        n_checks++; if (o_fetch_buff_en !== 1'b1 || o_count !== 3) begin n_fail++; $display("FAIL drain_reenable got en=%b cnt=%0d exp en=1 cnt=3", o_fetch_buff_en, o_count); end
      end
      if (i == 1) i_fetch_pkg = mk(32'h10, 1'b0);
    end
    n_checks++; if (o_dec_valid !== 1'b0 || o_count !== 0) begin n_fail++; $display("FAIL drain_empty got v=%b cnt=%0d exp v=0 cnt=0", o_dec_valid, o_count); end
    n_checks++; if (o_dec_pkg !== fetch_t'('0)) begin n_fail++; $display("FAIL drain_zero_pkg got %h exp 0", o_dec_pkg); end
    step();
    n_checks++; if (o_count !== 0) begin n_fail++; $display("FAIL empty_pop got %0d exp 0", o_count); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    i_dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pc = 32'h100 + 32'(4 * i);
      i_fetch_pkg = mk(pc, 1'b1);
      step();
      n_checks++; if (o_count !== 1 || o_dec_pkg !== mk(pc, 1'b1)) begin n_fail++; $display("FAIL stream[%0d] got cnt=%0d pkg=%h exp cnt=1 pkg=%h", i, o_count, o_dec_pkg, mk(pc, 1'b1)); end
    end
    i_fetch_pkg = mk(32'h0, 1'b0);
    step();
    n_checks++; if (o_count !== 0 || o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got cnt=%0d v=%b exp 0 0", o_count, o_dec_valid); end
  endtask

  task automatic test_bubbles();
    i_dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_fetch_pkg = mk(32'h200 + 32'(4 * (i / 2)), (i % 2) == 0);
      step();
      n_checks++; if (o_count !== (i / 2) + 1) begin n_fail++; $display("FAIL bubble_count[%0d] got %0d exp %0d", i, o_count, (i / 2) + 1); end
    end
    n_checks++; if (o_dec_pkg !== mk(32'h200, 1'b1)) begin n_fail++; $display("FAIL bubble_head got %h exp %h", o_dec_pkg, mk(32'h200, 1'b1)); end
  endtask

  task automatic test_flush_full();
    n_checks++; if (o_fetch_buff_en !== 1'b0) begin n_fail++; $display("FAIL pre_flush_en got %b exp 0", o_fetch_buff_en); end
    i_flush = 1'b1; i_dec_ready = 1'b1; i_fetch_pkg = mk(32'h300, 1'b1);
    #1;
    n_checks++; if (o_fetch_buff_en !== 1'b1) begin n_fail++; $display("FAIL flush_en got %b exp 1", o_fetch_buff_en); end
    step();
    i_flush = 1'b0;
    n_checks++; if (o_count !== 0 || o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got cnt=%0d v=%b exp 0 0", o_count, o_dec_valid); end
    i_fetch_pkg = mk(32'h80, 1'b0);
    step();
    n_checks++; if (o_count !== 0) begin n_fail++; $display("FAIL post_flush_bubble got %0d exp 0", o_count); end
    i_dec_ready = 1'b0;
    i_fetch_pkg = mk(32'h80, 1'b1);
    step();
    n_checks++; if (o_count !== 1 || o_dec_pkg !== mk(32'h80, 1'b1)) begin n_fail++; $display("FAIL redirect got cnt=%0d pkg=%h exp cnt=1 pkg=%h", o_count, o_dec_pkg, mk(32'h80, 1'b1)); end
  endtask

  task automatic test_simultaneous();
    i_dec_ready = 1'b0;
    i_fetch_pkg = mk(32'h84, 1'b1);
    step();
    n_checks++; if (o_count !== 2) begin n_fail++; $display("FAIL simul_setup got %0d exp 2", o_count); end
    i_dec_ready = 1'b1; i_flush = 1'b1; i_fetch_pkg = mk(32'h88, 1'b1);
    step();
    i_flush = 1'b0; i_fetch_pkg = mk(32'h0, 1'b0);
    n_checks++; if (o_count !== 0 || o_dec_valid !== 1'b0) begin n_fail++; $display("FAIL simul_flush got cnt=%0d v=%b exp 0 0", o_count, o_dec_valid); end
    step();
    n_checks++; if (o_count !== 0) begin n_fail++; $display("FAIL simul_nothing_stored got %0d exp 0", o_count); end
  endtask

  task automatic test_reset_mid();
    i_dec_ready = 1'b0;
    i_fetch_pkg = mk(32'h400, 1'b1);
    step();
    i_fetch_pkg = mk(32'h404, 1'b1);
    step();
    n_checks++; if (o_count !== 2) begin n_fail++; $display("FAIL mid_setup got %0d exp 2", o_count); end
    #1;
    i_rstn = 1'b0;
    #1;
    n_checks++; if (o_count !== 0 || o_dec_valid !== 1'b0 || o_fetch_buff_en !== 1'b1) begin n_fail++; $display("FAIL mid_reset got cnt=%0d v=%b en=%b exp 0 0 1", o_count, o_dec_valid, o_fetch_buff_en); end
    step();
    i_rstn = 1'b1;
    i_fetch_pkg = mk(32'h500, 1'b1);
    step();
    n_checks++; if (o_count !== 1 || o_dec_pkg !== mk(32'h500, 1'b1)) begin n_fail++; $display("FAIL post_reset_push got cnt=%0d pkg=%h exp cnt=1 pkg=%h", o_count, o_dec_pkg, mk(32'h500, 1'b1)); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_bubbles();
    test_flush_full();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
